// File: rtl/fcs_pkg.sv
`default_nettype none
// ============================================================================
// fcs_pkg : state type and CRC-32 constants shared by the FCS append block
// Revision: 1.0
// ============================================================================
package fcs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_PAD  = 2'd2,
      ST_FCS  = 2'd3
   } state_t;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   // Register value left after running the CRC over a frame plus its FCS
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage
`default_nettype wire

// File: rtl/fcs_append_ctrl_if.sv
`default_nettype none
// ============================================================================
// fcs_append_ctrl_if : byte-stream input and output handshakes of the FCS block
// Revision: 1.0
// ============================================================================
interface fcs_append_ctrl_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_sop;
   logic       in_eop;
   logic       in_ready;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_sop;
   logic       out_eop;
   logic       out_ready;

   modport slave (
      input  in_data, in_valid, in_sop, in_eop,
      output in_ready,
      output out_data, out_valid, out_sop, out_eop,
      input  out_ready
   );

   modport master (
      output in_data, in_valid, in_sop, in_eop,
      input  in_ready,
      input  out_data, out_valid, out_sop, out_eop,
      output out_ready
   );

endinterface
`default_nettype wire

// File: rtl/crc32_byte_step.sv
`default_nettype none
// ============================================================================
// crc32_byte_step : combinational reflected CRC-32 update by one byte, LSB first
// Revision: 1.0
// ============================================================================
module crc32_byte_step
   import fcs_pkg::*;
(
   input  wire logic [31:0] crc_in,
   input  wire logic [7:0]  d,
   output logic      [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) begin
            c = (c >> 1) ^ CRC_POLY_REFL;
         end else begin
            c = c >> 1;
         end
      end
      crc_out = c;
   end

endmodule
`default_nettype wire

// File: rtl/fcs_append_ctrl.sv
`default_nettype none
// ============================================================================
// fcs_append_ctrl : frames a byte stream, optionally pads it (FCS_PAD_EN) and
// appends the Ethernet FCS behind a single output register stage.
// Revision: 1.0
// ============================================================================
module fcs_append_ctrl
   import fcs_pkg::*;
#(
   parameter int unsigned MIN_FRAME_BYTES = 60
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   fcs_append_ctrl_if.slave bus,
   output logic             busy,
   output logic [15:0]      frame_count
);

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [1:0]  fcs_idx_q, fcs_idx_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_sop_q, out_sop_d;
   logic        out_eop_q, out_eop_d;
   logic [15:0] frame_count_q, frame_count_d;

   logic        w_load_en;
   logic        w_in_ready;
   logic        w_accept;
   logic [7:0]  w_crc_byte;
   logic [31:0] w_crc_next;
   logic [31:0] w_crc_inv;
   logic [7:0]  w_fcs_byte;
   logic [15:0] w_cnt_inc;
   state_t      w_eop_state;

   assign w_load_en  = !out_valid_q || bus.out_ready;
   assign w_in_ready = reset_n && w_load_en &&
                       ((state_q == ST_IDLE) || (state_q == ST_DATA));
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_cnt_inc  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign w_crc_inv  = ~crc_q;
   assign w_fcs_byte = w_crc_inv[{fcs_idx_q, 3'b000} +: 8];

`ifdef FCS_PAD_EN
   logic [15:0] w_eop_cnt;
   logic        w_pad_done;

   // Count including the eop byte itself; IDLE means a one-byte frame
   assign w_eop_cnt   = (state_q == ST_IDLE) ? 16'd1 : w_cnt_inc;
   assign w_eop_state = ({16'd0, w_eop_cnt} < 32'(MIN_FRAME_BYTES)) ? ST_PAD : ST_FCS;
   assign w_pad_done  = ({16'd0, w_cnt_inc} >= 32'(MIN_FRAME_BYTES));
   assign w_crc_byte  = (state_q == ST_PAD) ? 8'h00 : bus.in_data;
`else
   logic [15:0] w_unused_min;

   assign w_unused_min = MIN_FRAME_BYTES[15:0];
   assign w_eop_state  = ST_FCS;
   assign w_crc_byte   = bus.in_data;
`endif

   crc32_byte_step u_crc_step (
      .crc_in  (crc_q),
      .d       (w_crc_byte),
      .crc_out (w_crc_next)
   );

   always_comb begin
      state_d       = state_q;
      crc_d         = crc_q;
      byte_cnt_d    = byte_cnt_q;
      fcs_idx_d     = fcs_idx_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_sop_d     = out_sop_q;
      out_eop_d     = out_eop_q;
      frame_count_d = frame_count_q;

      // Nothing moves while the output register is stalled
      if (w_load_en) begin
         out_valid_d = 1'b0;
         out_sop_d   = 1'b0;
         out_eop_d   = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_accept && bus.in_sop) begin
                  crc_d       = w_crc_next;
                  byte_cnt_d  = 16'd1;
                  out_valid_d = 1'b1;
                  out_data_d  = bus.in_data;
                  out_sop_d   = 1'b1;
                  fcs_idx_d   = 2'd0;
                  state_d     = bus.in_eop ? w_eop_state : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  crc_d       = w_crc_next;
                  byte_cnt_d  = w_cnt_inc;
                  out_valid_d = 1'b1;
                  out_data_d  = bus.in_data;
                  fcs_idx_d   = 2'd0;
                  if (bus.in_eop) begin
                     state_d = w_eop_state;
                  end
               end
            end
`ifdef FCS_PAD_EN
            ST_PAD: begin
               crc_d       = w_crc_next;
               byte_cnt_d  = w_cnt_inc;
               out_valid_d = 1'b1;
               out_data_d  = 8'h00;
               fcs_idx_d   = 2'd0;
               if (w_pad_done) begin
                  state_d = ST_FCS;
               end
            end
`endif
            ST_FCS: begin
               out_valid_d = 1'b1;
               out_data_d  = w_fcs_byte;
               fcs_idx_d   = fcs_idx_q + 2'd1;
               if (fcs_idx_q == 2'd3) begin
                  out_eop_d     = 1'b1;
                  frame_count_d = frame_count_q + 16'd1;
                  crc_d         = CRC_INIT;
                  byte_cnt_d    = 16'd0;
                  fcs_idx_d     = 2'd0;
                  state_d       = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         crc_q         <= CRC_INIT;
         byte_cnt_q    <= 16'd0;
         fcs_idx_q     <= 2'd0;
         out_data_q    <= 8'h00;
         out_valid_q   <= 1'b0;
         out_sop_q     <= 1'b0;
         out_eop_q     <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         crc_q         <= crc_d;
         byte_cnt_q    <= byte_cnt_d;
         fcs_idx_q     <= fcs_idx_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_sop_q     <= out_sop_d;
         out_eop_q     <= out_eop_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sop   = out_sop_q;
   assign bus.out_eop   = out_eop_q;
   assign busy          = (state_q != ST_IDLE);
   assign frame_count   = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fcs_append_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fcs_append_ctrl : scoreboard bench for fcs_append_ctrl with a queue-based
// frame model; honours FCS_PAD_EN the same way as the design.
// Revision: 1.0
// ============================================================================
module tb_fcs_append_ctrl;

   localparam int unsigned MIN_FB = 60;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        busy;
   logic [15:0] frame_count;

   fcs_append_ctrl_if bus();

   fcs_append_ctrl #(.MIN_FRAME_BYTES(MIN_FB)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .busy        (busy),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   frames_done = 0;
   bit   rand_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Textbook reflected CRC-32: XOR the byte in, then shift eight times
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   task automatic push_frame(input logic [7:0] pl[$]);
      logic [7:0]  f[$];
      logic [31:0] c;
      f = pl;
`ifdef FCS_PAD_EN
      while (f.size() < MIN_FB) f.push_back(8'h00);
`endif
      c = 32'hFFFFFFFF;
      for (int i = 0; i < f.size(); i++) begin
         c = crc_upd(c, f[i]);
         exp_q.push_back('{d: f[i], s: (i == 0), e: 1'b0});
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back('{d: c[8*k +: 8], s: 1'b0, e: (k == 3)});
   endtask

   // Known-answer frames: fcs holds the four FCS bytes, first-sent in [7:0]
   task automatic push_lit(input logic [7:0] pl[$], input logic [31:0] fcs);
      for (int i = 0; i < pl.size(); i++) exp_q.push_back('{d: pl[i], s: (i == 0), e: 1'b0});
      for (int k = 0; k < 4; k++) exp_q.push_back('{d: fcs[8*k +: 8], s: 1'b0, e: (k == 3)});
   endtask

   task automatic send(input logic [7:0] d, input bit s, input bit e);
      bit acc;
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sop   = s;
      bus.in_eop   = e;
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready 0 required 1 at %0t", $time);
            break;
         end
      end
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] pl[$], input int mid);
      for (int i = 0; i < pl.size(); i++)
         send(pl[i], (i == 0) || (i == mid), (i == pl.size() - 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 6000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: pops the scoreboard on every output handshake
   initial begin
      exp_t        x;
      logic [31:0] mon_crc;
      logic [10:0] prev;
      bit          pstall;
      mon_crc = 32'hFFFFFFFF;
      pstall  = 1'b0;
      prev    = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pstall  = 1'b0;
            mon_crc = 32'hFFFFFFFF;
         end else begin
            if (pstall)
               chk("stall_hold", 32'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}),
                   32'(prev));
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: actual %0h required none", bus.out_data);
               end else begin
                  x = exp_q.pop_front();
                  chk("out_byte", 32'({bus.out_sop, bus.out_eop, bus.out_data}),
                      32'({x.s, x.e, x.d}));
               end
               mon_crc = crc_upd(mon_crc, bus.out_data);
               if (bus.out_eop) begin
                  frames_done++;
                  chk("frame_count", 32'(frame_count), 32'(frames_done[15:0]));
                  chk("residue", mon_crc, 32'hDEBB20E3);
                  mon_crc = 32'hFFFFFFFF;
               end
            end
            pstall = bus.out_valid && !bus.out_ready;
            prev   = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
         end
      end
   end

   initial begin
      logic [7:0] pl[$];
      int         len;
      int         mid;
      int         n;

      idle_in();
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // "123456789"
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef FCS_PAD_EN
      push_frame(pl);
`else
      push_lit(pl, 32'hCBF43926);
`endif
      send_frame(pl, -1);
      idle_in();
      drain();

      // single zero byte, sop and eop together
      pl = '{8'h00};
`ifdef FCS_PAD_EN
      push_frame(pl);
`else
      push_lit(pl, 32'hD202EF8D);
`endif
      send_frame(pl, -1);
      idle_in();
      drain();

      // bytes before sop are dropped, a mid-frame sop is payload
      send(8'hA5, 1'b0, 1'b0);
      send(8'h5A, 1'b0, 1'b1);
      idle_in();
      pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      push_frame(pl);
      send_frame(pl, 2);
      idle_in();
      drain();

      // random back-to-back frames with 50% output stalls
      rand_ready = 1'b1;
      for (int f = 0; f < 20; f++) begin
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
         len = $urandom_range(1, 70);
         pl.delete();
         for (int j = 0; j < len; j++) pl.push_back(8'($urandom));
         mid = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
         push_frame(pl);
         send_frame(pl, mid);
      end
      idle_in();
      drain();
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      // reset while the FCS bytes are being emitted
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      push_frame(pl);
      send_frame(pl, -1);
      idle_in();
      n = 0;
      while (exp_q.size() != 3 && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("reach_fcs", 32'(exp_q.size()), 32'd3);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_frame_count", 32'(frame_count), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      frames_done = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef FCS_PAD_EN
      push_frame(pl);
`else
      push_lit(pl, 32'hCBF43926);
`endif
      send_frame(pl, -1);
      idle_in();
      drain();
      chk("final_frame_count", 32'(frame_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fcs_append_ctrl.md
# fcs_append_ctrl

Frame-level sequencer that wraps a byte-wide CRC-32 datapath to generate and append the Ethernet FCS on an outgoing byte stream. It accepts framed bytes (sop/eop) from the MAC transmit path and owns the CRC register: it initialises it at frame start and updates it on every byte. It can optionally pad short frames, then emits the four FCS bytes after the payload. It sits between the transmit FIFO and the PHY byte interface, with valid/ready backpressure on both sides.

## Interface
- MIN_FRAME_BYTES, 60: minimum payload+pad length before FCS; only used when padding is compiled in; range 1..65535
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  8  payload byte
- in_valid  in  1  in_data/in_sop/in_eop valid
- in_sop  in  1  first byte of frame
- in_eop  in  1  last payload byte of frame
- in_ready  out  1  byte accepted when in_valid & in_ready
- out_data  out  8  payload, pad or FCS byte
- out_valid  out  1  out_* valid
- out_sop  out  1  first byte of output frame
- out_eop  out  1  last FCS byte
- out_ready  in  1  downstream accepts when out_valid & out_ready
- busy  out  1  state != IDLE
- frame_count  out  16  frames completed, wraps at 0xFFFF->0

## Operation
- States: IDLE, DATA, PAD, FCS. Reset: state=IDLE, crc=32'hFFFFFFFF, byte_cnt=0, fcs_idx=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, frame_count=0, busy=0, in_ready=0 while reset_n low.
- Output is a single register stage; it loads when load_en = !out_valid | out_ready.
- in_ready = load_en & (state==IDLE | state==DATA).
- IDLE: accepted byte with in_sop: crc = step(FFFFFFFF, byte), byte_cnt=1, emit with out_sop=1. Go to DATA, or to the eop path if in_eop is also set (1-byte frame). Accepted byte without in_sop is discarded: no output, no CRC update.
- DATA: each accepted byte updates crc and increments byte_cnt (saturating at 0xFFFF). A byte is passed to the output; in_sop in DATA is ignored and the byte is treated as payload.
- eop path: the accepted in_eop byte is emitted. Next state is PAD if padding is compiled in and byte_cnt < MIN_FRAME_BYTES; otherwise FCS with fcs_idx=0.
- PAD: on each load_en, emit 0x00, crc=step(crc,0x00), byte_cnt++. Go to FCS when byte_cnt reaches MIN_FRAME_BYTES.
- FCS: on each load_en, emit ~crc[8*fcs_idx+7 : 8*fcs_idx] and increment fcs_idx. At fcs_idx==3, set out_eop=1, increment frame_count, reset crc to FFFFFFFF and go to IDLE.
- CRC step: reflected CRC-32, polynomial 32'hEDB88320, LSB-first per byte. FCS byte order is crc[7:0] first.
- When out_valid=1 and out_ready=0, all state, crc and out_* hold.

## Timing
- Latency: byte accepted in cycle N appears on out_* in cycle N+1.
- Throughput: one byte/cycle with out_ready held high. An N-byte frame without padding occupies N+4 output cycles.
- The first FCS byte is presented the cycle after the eop byte, or after the last pad byte.
- The next frame's sop can be accepted the cycle after the last FCS byte is loaded into the output register.
- frame_count updates in the same cycle the last FCS byte loads into the output register.
- reset_n asserted mid-frame: all outputs immediately take their reset values. The partial frame is lost; no eop is generated.

## Configuration
- FCS_PAD_EN defined: the PAD state exists; frames shorter than MIN_FRAME_BYTES are zero-padded and the pad bytes are included in the CRC.
- FCS_PAD_EN undefined: the PAD state and comparator are removed; MIN_FRAME_BYTES is ignored and FCS always follows eop directly.

## Structure
- Package fcs_pkg holds:
  - the state enum
  - CRC_POLY_REFL = 32'hEDB88320
  - CRC_INIT = 32'hFFFFFFFF
  - CRC_RESIDUE = 32'hDEBB20E3, for checker reuse
- Sub-module crc32_byte_step: purely combinational next-CRC function (crc_in[31:0], d[7:0] -> crc_out[31:0]), instantiated once.

## Test plan
- FCS_PAD_EN off, frame "123456789" (0x31..0x39), out_ready=1 -> output is the 9 payload bytes then 26 39 F4 CB, out_eop on CB, frame_count=1.
- FCS_PAD_EN off, single byte 0x00 with sop&eop -> output 00 8D EF 02 D2, out_sop on 00, out_eop on D2.
- FCS_PAD_EN on, MIN_FRAME_BYTES=60, 9-byte "123456789" frame -> 9 bytes, 51 x 0x00, 4 FCS bytes matching the model CRC over 60 bytes. CRC over all 64 bytes gives residue DEBB20E3.
- Random out_ready toggling (50%) over 20 back-to-back random frames -> the byte stream equals the model, with no drop or duplicate and out_* stable while stalled.
- Bytes with in_valid but no sop while IDLE, then in_sop inside a frame -> the pre-sop bytes are dropped; the mid-frame sop byte is treated as payload in the CRC.
- reset_n pulsed low during the FCS state -> out_valid=0, frame_count=0, busy=0. The next frame "123456789" again yields 26 39 F4 CB.
